// File: rtl/mul_sequencer.sv
// Multi-cycle shift-and-add multiplier sequencer (IDLE -> RUN -> DONE) that stalls the pipeline for a MUL.
// Optional macro MUL_EARLY_EXIT_EN ends RUN as soon as no multiplier bits remain.
module mul_sequencer #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [3:0]       opcode,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0]       OP_MUL = 4'd9;
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_result;
    logic             r_busy;
    logic             r_done;

    logic             w_start;
    logic [WIDTH-1:0] w_accNext;
    logic             w_lastIter;

    assign w_start   = valid & (opcode == OP_MUL) & ~flush;
    assign w_accNext = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

`ifdef MUL_EARLY_EXIT_EN
    // Post-shift multiplier of zero means every remaining iteration would add nothing.
    assign w_lastIter = (r_count == LAST) | (r_mplier[WIDTH-1:1] == '0);
`else
    assign w_lastIter = (r_count == LAST);
`endif

    assign stall  = ((r_state == IDLE) & w_start) | (r_state == RUN);
    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_mcand  <= a;
                        r_mplier <= b;
                        r_acc    <= '0;
                        r_count  <= '0;
                        r_state  <= RUN;
                        r_busy   <= 1'b1;
                    end
                end
                RUN: begin
                    // A flush wins over the iteration so a squashed MUL never pulses done.
                    if (flush) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_acc    <= w_accNext;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_count  <= r_count + CNT_W'(1);
                        if (w_lastIter) begin
                            r_state  <= DONE;
                            r_result <= w_accNext;
                            r_done   <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard bench for mul_sequencer: products queued at start acceptance, compared on each done pulse.
// Latency expectations follow MUL_EARLY_EXIT_EN when it is defined for the build.
module tb_mul_sequencer;

    localparam int WIDTH = 64;
    localparam int CNT_W = 7;

    logic             clk = 1'b0;
    logic             reset;
    logic             valid;
    logic [3:0]       opcode;
    logic             flush;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    int               errors = 0;
    int               checks = 0;
    logic [WIDTH-1:0] expQ[$];
    logic [WIDTH-1:0] lastResult;

    mul_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .valid(valid), .opcode(opcode), .flush(flush),
        .a(a), .b(b), .stall(stall), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    // Cycles from start acceptance (T) to the done pulse.
    function automatic int expLatency(input logic [WIDTH-1:0] bv);
`ifdef MUL_EARLY_EXIT_EN
        int it = 1;
        for (int i = 0; i < WIDTH; i++) if (bv[i]) it = i + 1;
        return it + 1;
`else
        return WIDTH + 1;
`endif
    endfunction

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic startMul(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        valid = 1'b1; opcode = 4'd9; a = av; b = bv;
        expQ.push_back(av * bv);
        nextCycle();
        valid = 1'b0; opcode = 4'd0;
    endtask

    task automatic waitDone(input int maxCycles, output int cyc, output bit got);
        got = 1'b0;
        cyc = 1;
        while (cyc <= maxCycles) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got = 1'b1;
                return;
            end
            nextCycle();
            cyc++;
        end
    endtask

    function automatic logic [WIDTH-1:0] popExp();
        if (expQ.size() == 0) return 'x;
        return expQ.pop_front();
    endfunction

    task automatic test_reset();
        reset = 1'b0; valid = 1'b0; opcode = 4'd0; flush = 1'b0; a = '0; b = '0;
        repeat (3) nextCycle();
        @(negedge clk);
        checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b expected 0", stall); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (result !== '0) begin errors++; $display("[TB] FAIL reset_result: got %0h expected 0", result); end
        lastResult = '0;
        nextCycle();
        reset = 1'b1;
        nextCycle();
    endtask

    task automatic test_basic();
        int lat;
        int bad;
        logic [WIDTH-1:0] exp;
        lat = expLatency(64'd5);
        bad = 0;
        valid = 1'b1; opcode = 4'd9; a = 64'd3; b = 64'd5;
        expQ.push_back(64'd15);
        @(negedge clk);
        checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL basic_stall_start: got %b expected 1", stall); end
        nextCycle();
        valid = 1'b0; opcode = 4'd0;
        for (int c = 1; c < lat; c++) begin
            @(negedge clk);
            if (stall !== 1'b1 || busy !== 1'b1 || done !== 1'b0) bad++;
            nextCycle();
        end
        checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL basic_run_cycles: got %0d bad cycles expected 0", bad); end
        @(negedge clk);
        exp = popExp();
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL basic_done: got %b expected 1", done); end
        checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL basic_stall_done: got %b expected 0", stall); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy_done: got %b expected 1", busy); end
        checks++; if (result !== exp) begin errors++; $display("[TB] FAIL basic_result: got %0h expected %0h", result, exp); end
        lastResult = exp;
        nextCycle();
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_idle_after: got done=%b busy=%b expected 0/0", done, busy); end
        nextCycle();
    endtask

    task automatic test_wrap();
        logic [WIDTH-1:0] va[4];
        logic [WIDTH-1:0] vb[4];
        logic [WIDTH-1:0] exp;
        int cyc;
        bit got;
        va[0] = 64'hFFFF_FFFF_FFFF_FFFF; vb[0] = 64'd2;
        va[1] = 64'h8000_0000_0000_0000; vb[1] = 64'd2;
        va[2] = 64'hFFFF_FFFF_FFFF_FFFF; vb[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        va[3] = 64'h1234_5678_9ABC_DEF0; vb[3] = 64'h8000_0000_0000_0001;
        for (int i = 0; i < 4; i++) begin
            startMul(va[i], vb[i]);
            waitDone(200, cyc, got);
            exp = popExp();
            checks++; if (!got || cyc != expLatency(vb[i])) begin errors++; $display("[TB] FAIL wrap_latency[%0d]: got %0d (seen=%0b) expected %0d", i, cyc, got, expLatency(vb[i])); end
            checks++; if (result !== exp) begin errors++; $display("[TB] FAIL wrap_result[%0d]: got %0h expected %0h", i, result, exp); end
            lastResult = exp;
            nextCycle();
        end
    endtask

    task automatic test_early_exit();
        logic [WIDTH-1:0] va[6];
        logic [WIDTH-1:0] vb[6];
        logic [WIDTH-1:0] exp;
        int cyc;
        bit got;
        va[0] = 64'd11; vb[0] = 64'd1;
        va[1] = 64'd5;  vb[1] = 64'd0;
        va[2] = 64'd3;  vb[2] = 64'h8000_0000_0000_0000;
        for (int i = 3; i < 6; i++) begin
            va[i] = {$urandom(), $urandom()};
            vb[i] = {32'($urandom_range(0, 65535)), $urandom()};
        end
        for (int i = 0; i < 6; i++) begin
            startMul(va[i], vb[i]);
            waitDone(200, cyc, got);
            exp = popExp();
            checks++; if (!got || cyc != expLatency(vb[i])) begin errors++; $display("[TB] FAIL exit_latency[%0d]: got %0d (seen=%0b) expected %0d", i, cyc, got, expLatency(vb[i])); end
            checks++; if (result !== exp) begin errors++; $display("[TB] FAIL exit_result[%0d]: got %0h expected %0h", i, result, exp); end
            lastResult = exp;
            nextCycle();
        end
    endtask

    task automatic test_flush();
        int sawDone;
        logic [WIDTH-1:0] fb;
`ifdef MUL_EARLY_EXIT_EN
        fb = 64'h8000_0000_0000_0009;
`else
        fb = 64'd9;
`endif
        valid = 1'b1; opcode = 4'd9; a = 64'd7; b = fb;
        nextCycle();
        valid = 1'b0; opcode = 4'd0;
        repeat (9) nextCycle();
        flush = 1'b1;
        nextCycle();
        flush = 1'b0;
        @(negedge clk);
        checks++; if (stall !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_idle: got stall=%b busy=%b expected 0/0", stall, busy); end
        sawDone = 0;
        for (int c = 0; c < 70; c++) begin
            nextCycle();
            @(negedge clk);
            if (done === 1'b1) sawDone++;
        end
        checks++; if (sawDone !== 0) begin errors++; $display("[TB] FAIL flush_no_done: got %0d pulses expected 0", sawDone); end
        checks++; if (result !== lastResult) begin errors++; $display("[TB] FAIL flush_result_hold: got %0h expected %0h", result, lastResult); end
        nextCycle();
        valid = 1'b1; opcode = 4'd9; flush = 1'b1; a = 64'd4; b = 64'd4;
        @(negedge clk);
        checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL flush_blocks_stall: got %b expected 0", stall); end
        nextCycle();
        valid = 1'b0; opcode = 4'd0; flush = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_blocks_start: got busy=%b expected 0", busy); end
        nextCycle();
    endtask

    task automatic test_reset_mid();
        logic [WIDTH-1:0] exp;
        int cyc;
        bit got;
        valid = 1'b1; opcode = 4'd9; a = 64'd7; b = 64'h8000_0000_0000_0009;
        nextCycle();
        valid = 1'b0; opcode = 4'd0;
        repeat (19) nextCycle();
        reset = 1'b0;
        nextCycle();
        reset = 1'b1;
        @(negedge clk);
        checks++; if (stall !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL midreset_ctrl: got stall=%b busy=%b done=%b expected 0/0/0", stall, busy, done); end
        checks++; if (result !== '0) begin errors++; $display("[TB] FAIL midreset_result: got %0h expected 0", result); end
        lastResult = '0;
        nextCycle();
        startMul(64'd2, 64'd3);
        waitDone(200, cyc, got);
        exp = popExp();
        checks++; if (!got || cyc != expLatency(64'd3)) begin errors++; $display("[TB] FAIL midreset_latency: got %0d (seen=%0b) expected %0d", cyc, got, expLatency(64'd3)); end
        checks++; if (result !== exp) begin errors++; $display("[TB] FAIL midreset_result_after: got %0h expected %0h", result, exp); end
        lastResult = exp;
        nextCycle();
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] exp;
        int cyc;
        bit got;
        valid = 1'b1; opcode = 4'd9; a = 64'd4; b = 64'd5;
        expQ.push_back(64'd20);
        nextCycle();
        // Second instruction's operands appear while the first is still running.
        a = 64'd6; b = 64'd7;
        repeat (expLatency(64'd5) - 1) nextCycle();
        @(negedge clk);
        exp = popExp();
        checks++; if (done !== 1'b1 || stall !== 1'b0) begin errors++; $display("[TB] FAIL b2b_first_done: got done=%b stall=%b expected 1/0", done, stall); end
        checks++; if (result !== exp) begin errors++; $display("[TB] FAIL b2b_first_result: got %0h expected %0h", result, exp); end
        nextCycle();
        expQ.push_back(64'd42);
        @(negedge clk);
        checks++; if (busy !== 1'b0 || stall !== 1'b1 || done !== 1'b0) begin errors++; $display("[TB] FAIL b2b_gap: got busy=%b stall=%b done=%b expected 0/1/0", busy, stall, done); end
        nextCycle();
        valid = 1'b0; opcode = 4'd0;
        waitDone(200, cyc, got);
        exp = popExp();
        checks++; if (!got || cyc != expLatency(64'd7)) begin errors++; $display("[TB] FAIL b2b_second_latency: got %0d (seen=%0b) expected %0d", cyc, got, expLatency(64'd7)); end
        checks++; if (result !== exp) begin errors++; $display("[TB] FAIL b2b_second_result: got %0h expected %0h", result, exp); end
        lastResult = exp;
        nextCycle();
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle_end: got busy=%b expected 0", busy); end
        nextCycle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_early_exit();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
